// File: rtl/usb_chan_pkg.sv
// Shared types for the USB channel mux: packet header layout,
// TX/RX state encodings and the saturating counter helper.
package usb_chan_pkg;

  localparam logic [7:0] HdrMagic = 8'hA5;

  typedef struct packed {
    logic [7:0]  magic;
    logic [7:0]  chan_id;
    logic [15:0] len;
  } hdr_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_HDR,
    T_DATA
  } tx_state_e;

  typedef enum logic [1:0] {
    R_HDR,
    R_DATA,
    R_DROP
  } rx_state_e;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one above the last
// granted index; pointer moves only when advance is high.
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] grant_idx
);

  logic [IdxW-1:0] ptr_q;

  always_comb begin
    int   c;
    logic hit;
    hit       = 1'b0;
    c         = 0;
    grant_idx = ptr_q;
    grant     = '0;
    for (int i = 1; i <= N; i++) begin
      c = (int'(ptr_q) + i) % N;
      if (!hit && req[c]) begin
        hit       = 1'b1;
        grant_idx = IdxW'(c);
      end
    end
    if (hit) grant[grant_idx] = 1'b1;
  end

  // Reset to the top index so channel 0 wins the first round
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= IdxW'(N - 1);
    end else if (advance) begin
      ptr_q <= grant_idx;
    end
  end

endmodule

// File: rtl/usb_chan_mux.sv
// Merges per-channel TX streams into one framed PHY stream and
// splits the framed PHY RX stream back out to the channels.
module usb_chan_mux
  import usb_chan_pkg::*;
#(
  parameter int NumChan    = 4,
  parameter int MaxWaitCyc = 1023
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumChan*32-1:0] ch_tx_data_i,
  input  logic [NumChan*16-1:0] ch_tx_len_i,
  input  logic [NumChan-1:0]    ch_tx_valid_i,
  output logic [NumChan-1:0]    ch_tx_ready_o,
  output logic [31:0]           phy_tx_data_o,
  output logic                  phy_tx_valid_o,
  input  logic                  phy_tx_ready_i,
  input  logic [31:0]           phy_rx_data_i,
  input  logic                  phy_rx_valid_i,
  output logic                  phy_rx_ready_o,
  output logic [NumChan*32-1:0] ch_rx_data_o,
  output logic [NumChan-1:0]    ch_rx_valid_o,
  input  logic [NumChan-1:0]    ch_rx_ready_i,
  output logic [15:0]           err_magic_cnt_o,
  output logic [15:0]           err_chan_cnt_o,
  output logic [15:0]           err_tmo_cnt_o
);

  localparam int IdxW = (NumChan > 1) ? $clog2(NumChan) : 1;
  localparam logic [31:0] WdLast = 32'(MaxWaitCyc - 1);

  logic [31:0] tx_data [NumChan];
  logic [15:0] tx_len  [NumChan];

  for (genvar c = 0; c < NumChan; c++) begin : g_unpack
    assign tx_data[c] = ch_tx_data_i[c*32 +: 32];
    assign tx_len[c]  = ch_tx_len_i[c*16 +: 16];
  end

  tx_state_e       tx_q;
  logic [IdxW-1:0] gnt_q;
  logic [15:0]     tx_cnt_q;
  logic [31:0]     wd_q;
  logic            fill_q;

  logic [NumChan-1:0] arb_gnt;
  logic [IdxW-1:0]    arb_idx;
  logic               arb_adv;

  logic        gnt_valid;
  logic [31:0] gnt_data;
  logic [15:0] gnt_len;
  hdr_t        tx_hdr;
  logic        tx_xfer;

  assign gnt_valid = ch_tx_valid_i[gnt_q];
  assign gnt_data  = tx_data[gnt_q];
  assign gnt_len   = tx_len[gnt_q];
  assign tx_hdr    = '{magic:   HdrMagic,
                       chan_id: 8'(gnt_q),
                       len:     gnt_len};
  assign tx_xfer   = phy_tx_valid_o && phy_tx_ready_i;
  assign arb_adv   = (tx_q == T_IDLE) && (|arb_gnt);

  rr_arbiter #(
    .N (NumChan)
  ) u_arb (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .req       (ch_tx_valid_i),
    .advance   (arb_adv),
    .grant     (arb_gnt),
    .grant_idx (arb_idx)
  );

  always_comb begin
    phy_tx_data_o  = '0;
    phy_tx_valid_o = 1'b0;
    ch_tx_ready_o  = '0;
    if (rst_ni) begin
      unique case (tx_q)
        T_HDR: begin
          phy_tx_data_o  = tx_hdr;
          phy_tx_valid_o = 1'b1;
        end
        T_DATA: begin
          if (fill_q) begin
            phy_tx_valid_o = 1'b1;
          end else begin
            phy_tx_data_o        = gnt_data;
            phy_tx_valid_o       = gnt_valid;
            ch_tx_ready_o[gnt_q] = phy_tx_ready_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tx_q          <= T_IDLE;
      gnt_q         <= '0;
      tx_cnt_q      <= '0;
      wd_q          <= '0;
      fill_q        <= 1'b0;
      err_tmo_cnt_o <= '0;
    end else begin
      unique case (tx_q)
        T_HDR: begin
          if (phy_tx_ready_i) begin
            tx_cnt_q <= gnt_len;
            wd_q     <= '0;
            fill_q   <= 1'b0;
            tx_q     <= (gnt_len == 16'd0) ? T_IDLE : T_DATA;
          end
        end
        T_DATA: begin
          if (tx_xfer) begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
            if (tx_cnt_q == 16'd1) begin
              tx_q   <= T_IDLE;
              fill_q <= 1'b0;
            end
          end
          // Stall watchdog: only a silent channel counts, not PHY backpressure
          if (fill_q || gnt_valid) begin
            wd_q <= '0;
          end else if (wd_q == WdLast) begin
            wd_q          <= '0;
            fill_q        <= 1'b1;
            err_tmo_cnt_o <= sat_inc(err_tmo_cnt_o);
          end else begin
            wd_q <= wd_q + 32'd1;
          end
        end
        default: begin
          if (|arb_gnt) begin
            gnt_q <= arb_idx;
            tx_q  <= T_HDR;
          end
        end
      endcase
    end
  end

  rx_state_e       rx_q;
  logic [15:0]     rx_cnt_q;
  logic [IdxW-1:0] rx_chan_q;
  hdr_t            rx_hdr;
  logic            rx_chan_ok;
  logic            rx_xfer;

  assign rx_hdr       = hdr_t'(phy_rx_data_i);
  assign rx_chan_ok   = int'(rx_hdr.chan_id) < NumChan;
  assign rx_xfer      = phy_rx_valid_i && phy_rx_ready_o;
  assign ch_rx_data_o = {NumChan{phy_rx_data_i}};

  always_comb begin
    phy_rx_ready_o = 1'b0;
    ch_rx_valid_o  = '0;
    if (rst_ni) begin
      unique case (rx_q)
        R_DATA: begin
          ch_rx_valid_o[rx_chan_q] = phy_rx_valid_i;
          phy_rx_ready_o = ch_rx_ready_i[rx_chan_q];
        end
        default: phy_rx_ready_o = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_q            <= R_HDR;
      rx_cnt_q        <= '0;
      rx_chan_q       <= '0;
      err_magic_cnt_o <= '0;
      err_chan_cnt_o  <= '0;
    end else if (rx_xfer) begin
      unique case (rx_q)
        R_DATA, R_DROP: begin
          rx_cnt_q <= rx_cnt_q - 16'd1;
          if (rx_cnt_q == 16'd1) rx_q <= R_HDR;
        end
        default: begin
          if (rx_hdr.magic != HdrMagic) begin
            err_magic_cnt_o <= sat_inc(err_magic_cnt_o);
          end else if (!rx_chan_ok) begin
            err_chan_cnt_o <= sat_inc(err_chan_cnt_o);
            rx_cnt_q       <= rx_hdr.len;
            if (rx_hdr.len != 16'd0) rx_q <= R_DROP;
          end else if (rx_hdr.len != 16'd0) begin
            rx_cnt_q  <= rx_hdr.len;
            rx_chan_q <= rx_hdr.chan_id[IdxW-1:0];
            rx_q      <= R_DATA;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_chan_mux.sv
// Directed bench for usb_chan_mux: TX framing, arbitration,
// watchdog filler, RX demux, error counters and reset.
module tb_usb_chan_mux;

  localparam int NC = 4;
  localparam int MW = 8;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic [NC*32-1:0] ch_tx_data_i;
  logic [NC*16-1:0] ch_tx_len_i;
  logic [NC-1:0]  ch_tx_valid_i;
  logic [NC-1:0]  ch_tx_ready_o;
  logic [31:0]    phy_tx_data_o;
  logic           phy_tx_valid_o;
  logic           phy_tx_ready_i;
  logic [31:0]    phy_rx_data_i;
  logic           phy_rx_valid_i;
  logic           phy_rx_ready_o;
  logic [NC*32-1:0] ch_rx_data_o;
  logic [NC-1:0]  ch_rx_valid_o;
  logic [NC-1:0]  ch_rx_ready_i;
  logic [15:0]    err_magic_cnt_o;
  logic [15:0]    err_chan_cnt_o;
  logic [15:0]    err_tmo_cnt_o;

  usb_chan_mux #(
    .NumChan    (NC),
    .MaxWaitCyc (MW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .ch_tx_data_i    (ch_tx_data_i),
    .ch_tx_len_i     (ch_tx_len_i),
    .ch_tx_valid_i   (ch_tx_valid_i),
    .ch_tx_ready_o   (ch_tx_ready_o),
    .phy_tx_data_o   (phy_tx_data_o),
    .phy_tx_valid_o  (phy_tx_valid_o),
    .phy_tx_ready_i  (phy_tx_ready_i),
    .phy_rx_data_i   (phy_rx_data_i),
    .phy_rx_valid_i  (phy_rx_valid_i),
    .phy_rx_ready_o  (phy_rx_ready_o),
    .ch_rx_data_o    (ch_rx_data_o),
    .ch_rx_valid_o   (ch_rx_valid_o),
    .ch_rx_ready_i   (ch_rx_ready_i),
    .err_magic_cnt_o (err_magic_cnt_o),
    .err_chan_cnt_o  (err_chan_cnt_o),
    .err_tmo_cnt_o   (err_tmo_cnt_o)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;
  int cyc = 0;

  logic [31:0] txq [NC][$];
  logic [15:0] txlen [NC] = '{default: 16'd0};
  int          head [NC] = '{default: 0};
  logic [NC-1:0] pop = '0;
  int acc_cnt [NC] = '{default: 0};
  int rdy_cnt [NC] = '{default: 0};
  int rxv_cnt = 0;
  int rx_stall = 0;
  logic [31:0] txlog [$];
  int          txcyc [$];
  logic [39:0] rxlog [$];

  // channel sources: each channel streams its queue, holding data until accepted
  initial begin
    ch_tx_valid_i = '0;
    ch_tx_data_i  = '0;
    ch_tx_len_i   = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < NC; c++) begin
        if (pop[c]) head[c]++;
        ch_tx_len_i[c*16 +: 16] = txlen[c];
        if (head[c] < txq[c].size()) begin
          ch_tx_valid_i[c] = 1'b1;
          ch_tx_data_i[c*32 +: 32] = txq[c][head[c]];
        end else begin
          ch_tx_valid_i[c] = 1'b0;
          ch_tx_data_i[c*32 +: 32] = '0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int c = 0; c < NC; c++) begin
        pop[c] = ch_tx_valid_i[c] && ch_tx_ready_o[c];
        if (pop[c]) acc_cnt[c]++;
        if (ch_tx_ready_o[c]) rdy_cnt[c]++;
        if (ch_rx_valid_o[c]) rxv_cnt++;
        if (ch_rx_valid_o[c] && ch_rx_ready_i[c])
          rxlog.push_back({8'(c), ch_rx_data_o[c*32 +: 32]});
      end
      if (phy_tx_valid_o && phy_tx_ready_i) begin
        txlog.push_back(phy_tx_data_o);
        txcyc.push_back(cyc);
      end
      if (phy_rx_valid_i && !phy_rx_ready_o) rx_stall++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (txlog.size() < n && k < budget) begin
      tick();
      k++;
    end
    vecs++;
    if (txlog.size() < n) begin
      miss++;
      $display("FAIL tx_wait: got %0d words want %0d", txlog.size(), n);
    end
  endtask

  task automatic send_rx(input logic [31:0] w);
    int n = 0;
    phy_rx_data_i  = w;
    phy_rx_valid_i = 1'b1;
    @(negedge clk);
    while (!phy_rx_ready_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    vecs++;
    if (!phy_rx_ready_o) begin
      miss++;
      $display("FAIL rx_send %h: not accepted in %0d cycles", w, n);
    end
    tick();
    phy_rx_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    phy_tx_ready_i = 1'b1;
    phy_rx_data_i  = 32'hA5000003;
    phy_rx_valid_i = 1'b1;
    ch_rx_ready_i  = '1;
    tick();
    tick();
    vecs += 7;
    if (phy_tx_valid_o !== 1'b0) begin
      miss++; $display("FAIL rst_phy_tx_valid: got %b want 0", phy_tx_valid_o);
    end
    if (ch_tx_ready_o !== 4'h0) begin
      miss++; $display("FAIL rst_ch_tx_ready: got %h want 0", ch_tx_ready_o);
    end
    if (ch_rx_valid_o !== 4'h0) begin
      miss++; $display("FAIL rst_ch_rx_valid: got %h want 0", ch_rx_valid_o);
    end
    if (phy_rx_ready_o !== 1'b0) begin
      miss++; $display("FAIL rst_phy_rx_ready: got %b want 0", phy_rx_ready_o);
    end
    if (err_magic_cnt_o !== 16'd0) begin
      miss++; $display("FAIL rst_err_magic: got %h want 0", err_magic_cnt_o);
    end
    if (err_chan_cnt_o !== 16'd0) begin
      miss++; $display("FAIL rst_err_chan: got %h want 0", err_chan_cnt_o);
    end
    if (err_tmo_cnt_o !== 16'd0) begin
      miss++; $display("FAIL rst_err_tmo: got %h want 0", err_tmo_cnt_o);
    end
    phy_rx_valid_i = 1'b0;
    rst_ni = 1'b1;
    tick();
    vecs += 2;
    if (phy_rx_ready_o !== 1'b1) begin
      miss++; $display("FAIL post_rst_rx_ready: got %b want 1", phy_rx_ready_o);
    end
    if (phy_tx_valid_o !== 1'b0) begin
      miss++; $display("FAIL post_rst_tx_valid: got %b want 0", phy_tx_valid_o);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] e [12] = '{32'hA5000001, 32'hA0, 32'hA5020001, 32'hC0,
                            32'hA5000001, 32'hA1, 32'hA5020001, 32'hC1,
                            32'hA5000001, 32'hA2, 32'hA5020001, 32'hC2};
    int n0 = txlog.size();
    txlen[0] = 16'd1;
    txlen[2] = 16'd1;
    for (int i = 0; i < 3; i++) begin
      txq[0].push_back(32'hA0 + 32'(i));
      txq[2].push_back(32'hC0 + 32'(i));
    end
    wait_tx(n0 + 12, 80);
    for (int i = 0; i < 12; i++) begin
      vecs++;
      if (txlog[n0+i] !== e[i]) begin
        miss++;
        $display("FAIL rr[%0d]: got %h want %h", i, txlog[n0+i], e[i]);
      end
    end
  endtask

  task automatic test_tx_basic();
    logic [31:0] e [4] = '{32'hA5010003, 32'h11, 32'h22, 32'h33};
    int n0 = txlog.size();
    int r0 = rdy_cnt[1];
    txlen[1] = 16'd3;
    txq[1].push_back(32'h11);
    txq[1].push_back(32'h22);
    txq[1].push_back(32'h33);
    wait_tx(n0 + 4, 40);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (txlog[n0+i] !== e[i]) begin
        miss++;
        $display("FAIL basic[%0d]: got %h want %h", i, txlog[n0+i], e[i]);
      end
    end
    vecs++;
    if (rdy_cnt[1] - r0 !== 3) begin
      miss++;
      $display("FAIL basic_ready_pulses: got %0d want 3", rdy_cnt[1] - r0);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e [3] = '{32'hA5030002, 32'h61, 32'h62};
    int n0 = txlog.size();
    int a0 = acc_cnt[3];
    txlen[3] = 16'd2;
    txq[3].push_back(32'h61);
    txq[3].push_back(32'h62);
    for (int k = 0; k < 10; k++) begin
      phy_tx_ready_i = (k % 3) == 2;
      tick();
    end
    phy_tx_ready_i = 1'b1;
    wait_tx(n0 + 3, 40);
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (txlog[n0+i] !== e[i]) begin
        miss++;
        $display("FAIL bp[%0d]: got %h want %h", i, txlog[n0+i], e[i]);
      end
    end
    vecs++;
    if (acc_cnt[3] - a0 !== 2) begin
      miss++;
      $display("FAIL bp_beats: got %0d want 2", acc_cnt[3] - a0);
    end
  endtask

  task automatic test_back_to_back();
    int n0 = txlog.size();
    txlen[1] = 16'd1;
    txq[1].push_back(32'h51);
    txq[1].push_back(32'h52);
    wait_tx(n0 + 4, 40);
    vecs += 2;
    if (txlog[n0+2] !== 32'hA5010001) begin
      miss++;
      $display("FAIL b2b_hdr2: got %h want A5010001", txlog[n0+2]);
    end
    if (txcyc[n0+2] - txcyc[n0] !== 3) begin
      miss++;
      $display("FAIL b2b_gap: got %0d cycles want 3", txcyc[n0+2] - txcyc[n0]);
    end
  endtask

  task automatic test_rx_magic();
    int l0 = rxlog.size();
    int s0 = rx_stall;
    ch_rx_ready_i = 4'b1011;
    send_rx(32'h12345678);
    send_rx(32'hA5020002);
    fork
      send_rx(32'hAA);
      begin
        repeat (5) tick();
        ch_rx_ready_i = 4'hF;
      end
    join
    send_rx(32'hBB);
    tick();
    vecs += 5;
    if (err_magic_cnt_o !== 16'd1) begin
      miss++; $display("FAIL rx_err_magic: got %0d want 1", err_magic_cnt_o);
    end
    if (rxlog.size() - l0 !== 2) begin
      miss++; $display("FAIL rx_count: got %0d want 2", rxlog.size() - l0);
    end
    if (rxlog[l0] !== {8'd2, 32'hAA}) begin
      miss++; $display("FAIL rx_word0: got %h want 02000000aa", rxlog[l0]);
    end
    if (rxlog[l0+1] !== {8'd2, 32'hBB}) begin
      miss++; $display("FAIL rx_word1: got %h want 02000000bb", rxlog[l0+1]);
    end
    if (rx_stall - s0 !== 5) begin
      miss++; $display("FAIL rx_stall: got %0d want 5", rx_stall - s0);
    end
  endtask

  task automatic test_rx_badchan();
    int v0 = rxv_cnt;
    int l0 = rxlog.size();
    send_rx(32'hA5070002);
    send_rx(32'h111);
    send_rx(32'h222);
    tick();
    vecs += 2;
    if (err_chan_cnt_o !== 16'd1) begin
      miss++; $display("FAIL bad_err_chan: got %0d want 1", err_chan_cnt_o);
    end
    if (rxv_cnt - v0 !== 0) begin
      miss++; $display("FAIL bad_no_valid: got %0d want 0", rxv_cnt - v0);
    end
    send_rx(32'hA5000000);
    send_rx(32'hA5010001);
    send_rx(32'hCAFE);
    tick();
    vecs += 3;
    if (rxlog.size() - l0 !== 1 || rxlog[l0] !== {8'd1, 32'hCAFE}) begin
      miss++;
      $display("FAIL bad_resync: got %0d words, %h want 1, 010000cafe",
               rxlog.size() - l0, rxlog[l0]);
    end
    if (err_magic_cnt_o !== 16'd1) begin
      miss++; $display("FAIL bad_magic_hold: got %0d want 1", err_magic_cnt_o);
    end
    if (err_chan_cnt_o !== 16'd1) begin
      miss++; $display("FAIL bad_chan_hold: got %0d want 1", err_chan_cnt_o);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] e [7] = '{32'hA5030004, 32'h77, 32'h0, 32'h0, 32'h0,
                           32'hA5010001, 32'h05};
    int n0 = txlog.size();
    txlen[3] = 16'd4;
    txq[3].push_back(32'h77);
    wait_tx(n0 + 5, 60);
    vecs++;
    if (err_tmo_cnt_o !== 16'd1) begin
      miss++; $display("FAIL tmo_cnt: got %0d want 1", err_tmo_cnt_o);
    end
    txlen[1] = 16'd1;
    txq[1].push_back(32'h05);
    wait_tx(n0 + 7, 40);
    for (int i = 0; i < 7; i++) begin
      vecs++;
      if (txlog[n0+i] !== e[i]) begin
        miss++;
        $display("FAIL tmo[%0d]: got %h want %h", i, txlog[n0+i], e[i]);
      end
    end
    vecs++;
    if (txcyc[n0+2] - txcyc[n0+1] !== MW + 1) begin
      miss++;
      $display("FAIL tmo_delay: got %0d want %0d",
               txcyc[n0+2] - txcyc[n0+1], MW + 1);
    end
  endtask

  task automatic test_reset_mid();
    int n0 = txlog.size();
    int n1;
    txlen[2] = 16'd4;
    txq[2].push_back(32'h21);
    txq[2].push_back(32'h22);
    wait_tx(n0 + 3, 40);
    rst_ni = 1'b0;
    #1;
    vecs += 4;
    if (phy_tx_valid_o !== 1'b0) begin
      miss++; $display("FAIL mid_tx_valid: got %b want 0", phy_tx_valid_o);
    end
    if (ch_tx_ready_o !== 4'h0) begin
      miss++; $display("FAIL mid_tx_ready: got %h want 0", ch_tx_ready_o);
    end
    if (ch_rx_valid_o !== 4'h0) begin
      miss++; $display("FAIL mid_rx_valid: got %h want 0", ch_rx_valid_o);
    end
    if (phy_rx_ready_o !== 1'b0) begin
      miss++; $display("FAIL mid_rx_ready: got %b want 0", phy_rx_ready_o);
    end
    txlen[0] = 16'd1;
    txq[0].push_back(32'h31);
    txlen[2] = 16'd1;
    txq[2].push_back(32'h41);
    tick();
    vecs += 3;
    if (err_magic_cnt_o !== 16'd0) begin
      miss++; $display("FAIL mid_err_magic: got %0d want 0", err_magic_cnt_o);
    end
    if (err_chan_cnt_o !== 16'd0) begin
      miss++; $display("FAIL mid_err_chan: got %0d want 0", err_chan_cnt_o);
    end
    if (err_tmo_cnt_o !== 16'd0) begin
      miss++; $display("FAIL mid_err_tmo: got %0d want 0", err_tmo_cnt_o);
    end
    tick();
    n1 = txlog.size();
    rst_ni = 1'b1;
    wait_tx(n1 + 4, 40);
    vecs += 5;
    if (n1 !== n0 + 3) begin
      miss++; $display("FAIL mid_no_words: got %0d want %0d", n1, n0 + 3);
    end
    if (txlog[n1] !== 32'hA5000001) begin
      miss++; $display("FAIL mid_first_hdr: got %h want A5000001", txlog[n1]);
    end
    if (txlog[n1+1] !== 32'h31) begin
      miss++; $display("FAIL mid_first_data: got %h want 31", txlog[n1+1]);
    end
    if (txlog[n1+2] !== 32'hA5020001) begin
      miss++; $display("FAIL mid_second_hdr: got %h want A5020001", txlog[n1+2]);
    end
    if (txlog[n1+3] !== 32'h41) begin
      miss++; $display("FAIL mid_second_data: got %h want 41", txlog[n1+3]);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_tx_basic();
    test_backpressure();
    test_back_to_back();
    test_rx_magic();
    test_rx_badchan();
    test_timeout();
    test_reset_mid();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/usb_chan_mux.md
USB_CHAN_MUX -- requirements
Module: usb_chan_mux

Interface
REQ-001 SHALL have parameter NumChan, default 4, number of logical channels (1..256).
REQ-002 SHALL have parameter MaxWaitCyc, default 1023, watchdog limit for a stalled TX payload.
REQ-003 SHALL have port clk_i  input  1  sys_clk domain clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ch_tx_data_i / ch_tx_len_i / ch_tx_valid_i  input  NumChan x 32 / NumChan x 16 / NumChan  per-channel TX word, packet length in words (held stable while valid), valid.
REQ-006 SHALL have port ch_tx_ready_o  output  NumChan  per-channel TX accept.
REQ-007 SHALL have port phy_tx_data_o / phy_tx_valid_o  output  32 / 1  and phy_tx_ready_i  input  1  merged stream to CDC TX FIFO.
REQ-008 SHALL have port phy_rx_data_i / phy_rx_valid_i  input  32 / 1  and phy_rx_ready_o  output  1  merged stream from CDC RX FIFO.
REQ-009 SHALL have port ch_rx_data_o / ch_rx_valid_o  output  NumChan x 32 / NumChan  and ch_rx_ready_i  input  NumChan  per-channel RX stream.
REQ-010 SHALL have port err_magic_cnt_o / err_chan_cnt_o / err_tmo_cnt_o  output  16 each  saturating error counters.

Function
REQ-011 Header word SHALL be {magic 8'hA5 [31:24], chan_id [23:16], len [15:0]}; len payload words follow; len=0 is a header-only packet.
REQ-012 Handshake SHALL be valid/ready: transfer when both high; valid never depends on ready; data/valid held until accepted.
REQ-013 TX FSM states SHALL be T_IDLE, T_HDR, T_DATA.
REQ-014 T_IDLE: round-robin over ch_tx_valid_i, starting one above the last granted channel; grant registered; -> T_HDR next cycle.
REQ-015 T_HDR: drive header from granted channel's len; on phy_tx_ready_i -> T_DATA (len>0, counter=len) or T_IDLE (len=0); no ch_tx_ready_o pulse for the header.
REQ-016 T_DATA: phy_tx_data_o/valid combinationally = granted channel data/valid; ch_tx_ready_o[grant]=phy_tx_ready_i, all others 0; decrement counter per transfer; last transfer -> T_IDLE.
REQ-017 Data beats SHALL be consumed only in T_DATA; the first beat is the first payload word (len is sampled with it, not consumed separately).
REQ-018 T_DATA stall (granted valid low) for MaxWaitCyc consecutive cycles SHALL emit 32'h0 filler for remaining words, increment err_tmo_cnt_o, -> T_IDLE.
REQ-019 Grant SHALL NOT change mid-packet; a single requesting channel back-to-back SHALL be re-granted with one T_IDLE cycle between packets.
REQ-020 RX FSM states SHALL be R_HDR, R_DATA, R_DROP.
REQ-021 R_HDR: phy_rx_ready_o=1; magic!=A5 -> discard word, err_magic_cnt_o+1, stay; chan_id>=NumChan -> err_chan_cnt_o+1, R_DROP (len>0); valid, len>0 -> R_DATA; len=0 -> stay.
REQ-022 R_DATA: ch_rx_valid_o[chan]=phy_rx_valid_i, data broadcast to all channel outputs, phy_rx_ready_o=ch_rx_ready_i[chan]; count transfers; last -> R_HDR.
REQ-023 R_DROP: phy_rx_ready_o=1, discard len words, -> R_HDR.
REQ-024 TX and RX FSMs SHALL be independent; simultaneous events in both SHALL not interact.
REQ-025 Error counters SHALL saturate at 16'hFFFF; no wrap.
REQ-026 Latency: header appears on phy_tx one cycle after T_IDLE arbitration; payload pass-through zero-cycle combinational.

Reset
REQ-027 On rst_ni low at clk_i edge: TX->T_IDLE, RX->R_HDR, RR pointer=NumChan-1 (channel 0 first), counters/watchdog=0.
REQ-028 During reset: phy_tx_valid_o=0, ch_tx_ready_o=0, ch_rx_valid_o=0, phy_rx_ready_o=0, err counters=0.
REQ-029 Reset mid-packet SHALL abandon the packet; no header/filler completion after deassertion.

Structure
REQ-030 usb_chan_pkg SHALL hold HdrMagic (8'hA5), header struct typedef (magic, chan_id, len), TX/RX state enums.
REQ-031 Round-robin arbiter SHALL be sub-module rr_arbiter (parameter N; req, advance, grant one-hot, grant index).

Verification
REQ-032 Ch1 valid, len=3, words 11,22,33 -> phy_tx: A5010003, 11, 22, 33; ch_tx_ready_o[1] exactly 3 pulses.
REQ-033 Ch0 and ch2 request continuously, len=1 -> headers alternate A5000001, A5020001, A5000001.
REQ-034 phy_rx: 12345678, A5020002, AA, BB -> err_magic_cnt_o=1; ch_rx[2] gets AA, BB; with ch_rx_ready_i[2] low 5 cycles, phy_rx_ready_o low 5 cycles.
REQ-035 phy_rx: A5070002, X, Y (NumChan=4) -> err_chan_cnt_o=1; no ch_rx_valid_o; next A5000000 parsed normally.
REQ-036 Ch3 len=4, valid drops after 1 word for MaxWaitCyc -> three 00000000 words, err_tmo_cnt_o=1, then next grant.
REQ-037 Assert rst_ni low during T_DATA -> next cycle all valids 0, counters 0; post-reset first packet starts with header from channel 0 if requesting.
